// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave that maps one burst at a time onto a synchronous
// 32-bit SRAM port (read data returns the cycle after the read strobe).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; AR/AW arbitrated, ready only here
// RD_REQ  | SRAM read strobe for the current beat
// RD_WAIT | SRAM read data returns and is captured into rdata
// RD_RESP | rvalid held with stable payload until rready
// WR_DATA | wready high; each W beat is written straight through to SRAM
// WR_RESP | bvalid held with latched bid/bresp until bready
module axi_sram_slave #(
  parameter int SRAM_AW = 16
) (
  input  logic               aclk,
  input  logic               areset,
  // read address channel
  input  logic [3:0]         arid,
  input  logic [31:0]        araddr,
  input  logic [3:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic [1:0]         arburst,
  input  logic [1:0]         arlock,
  input  logic [3:0]         arcache,
  input  logic [2:0]         arprot,
  input  logic               arvalid,
  output logic               arready,
  // read data channel
  output logic [3:0]         rid,
  output logic [31:0]        rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  // write address channel
  input  logic [3:0]         awid,
  input  logic [31:0]        awaddr,
  input  logic [3:0]         awlen,
  input  logic [2:0]         awsize,
  input  logic [1:0]         awburst,
  input  logic [1:0]         awlock,
  input  logic [3:0]         awcache,
  input  logic [2:0]         awprot,
  input  logic               awvalid,
  output logic               awready,
  // write data channel
  input  logic [3:0]         wid,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  input  logic               wlast,
  input  logic               wvalid,
  output logic               wready,
  // write response channel
  output logic [3:0]         bid,
  output logic [1:0]         bresp,
  output logic               bvalid,
  input  logic               bready,
  // SRAM master port
  output logic               sram_en,
  output logic [3:0]         sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_RESP,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t state;
  state_t state_next;

  // latched transaction context (shared by read and write, one in flight)
  logic [3:0]         txn_id;
  logic [SRAM_AW-1:0] addr;
  logic [3:0]         len;
  logic [1:0]         burst;
  logic [3:0]         beat;

  // set after a read grant so a simultaneous request next time goes to write
  logic               prefer_wr;

  logic [31:0]        rdata_q;
  logic [1:0]         bresp_q;

  logic               burst_ok;
  logic               last_beat;
  logic [SRAM_AW-1:0] addr_next;
  logic               ar_hs;
  logic               aw_hs;
  logic               r_hs;
  logic               w_hs;

  // WRAP and reserved encodings never touch the SRAM and answer SLVERR
  assign burst_ok  = (burst == BURST_FIXED) || (burst == BURST_INCR);
  assign last_beat = (beat == len);
  // word address wraps naturally at the SRAM_AW boundary
  assign addr_next = (burst == BURST_INCR) ? addr + {{(SRAM_AW-1){1'b0}}, 1'b1} : addr;

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign r_hs  = rvalid && rready;
  assign w_hs  = wvalid && wready;

  assign rid        = txn_id;
  assign bid        = txn_id;
  assign rdata      = rdata_q;
  assign rresp      = ((state == RD_RESP) && !burst_ok) ? RESP_SLVERR : RESP_OKAY;
  assign rlast      = (state == RD_RESP) && last_beat;
  assign bresp      = bresp_q;
  assign sram_addr  = addr;
  assign sram_wdata = wdata;

  // state register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state decode plus handshake and SRAM strobe outputs
  always_comb begin
    state_next = state;
    arready    = 1'b0;
    awready    = 1'b0;
    rvalid     = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 4'b0000;

    case (state)
      IDLE: begin
        // only the favoured channel is offered ready when both request,
        // so two handshakes can never happen in the same cycle
        arready = !areset && !(awvalid && prefer_wr);
        awready = !areset && !(arvalid && !prefer_wr);
        if (arvalid && arready) begin
          state_next = RD_REQ;
        end else if (awvalid && awready) begin
          state_next = WR_DATA;
        end
      end

      RD_REQ: begin
        sram_en    = burst_ok;
        state_next = RD_WAIT;
      end

      RD_WAIT: begin
        state_next = RD_RESP;
      end

      RD_RESP: begin
        rvalid = 1'b1;
        if (rready) begin
          state_next = last_beat ? IDLE : RD_REQ;
        end
      end

      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          sram_en = burst_ok;
          sram_we = burst_ok ? wstrb : 4'b0000;
          if (wlast) begin
            state_next = WR_RESP;
          end
        end
      end

      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // transaction context: latched on address handshake, stepped per beat
  always_ff @(posedge aclk) begin
    if (areset) begin
      txn_id    <= 4'h0;
      addr      <= '0;
      len       <= 4'h0;
      burst     <= BURST_FIXED;
      beat      <= 4'h0;
      prefer_wr <= 1'b0;
    end else begin
      if (ar_hs) begin
        txn_id    <= arid;
        addr      <= araddr[SRAM_AW+1:2];
        len       <= arlen;
        burst     <= arburst;
        beat      <= 4'h0;
        prefer_wr <= 1'b1;
      end else if (aw_hs) begin
        txn_id    <= awid;
        addr      <= awaddr[SRAM_AW+1:2];
        len       <= awlen;
        burst     <= awburst;
        beat      <= 4'h0;
        prefer_wr <= 1'b0;
      end

      if ((r_hs && !last_beat) || w_hs) begin
        beat <= beat + 4'd1;
        addr <= addr_next;
      end
    end
  end

  // read data register: SRAM data captured the cycle after the strobe
  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata_q <= 32'h0;
    end else if (state == RD_WAIT) begin
      rdata_q <= burst_ok ? sram_rdata : 32'h0;
    end
  end

  // write response: decided on the beat carrying wlast
  always_ff @(posedge aclk) begin
    if (areset) begin
      bresp_q <= RESP_OKAY;
    end else if (w_hs && wlast) begin
      bresp_q <= (!burst_ok || !last_beat) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // size, lock, cache, prot, write id and out-of-range address bits carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{arsize, arlock, arcache, arprot, araddr[31:SRAM_AW+2], araddr[1:0],
                           awsize, awlock, awcache, awprot, awaddr[31:SRAM_AW+2], awaddr[1:0],
                           wid};

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter SRAM_AW, default 16, meaning SRAM word-address width (2^SRAM_AW 32-bit words).
REQ-002 SHALL have port aclk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port areset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have AR slave ports: arid in 4, araddr in 32, arlen in 4, arsize in 3, arburst in 2, arvalid in 1, arready out 1 (arlock/arcache/arprot in, ignored).
REQ-005 SHALL have R slave ports: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.
REQ-006 SHALL have AW slave ports: awid in 4, awaddr in 32, awlen in 4, awsize in 3, awburst in 2, awvalid in 1, awready out 1 (awlock/awcache/awprot in, ignored).
REQ-007 SHALL have W ports wid in 4 (ignored), wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1; B ports bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-008 SHALL have SRAM master ports: sram_en out 1, sram_we out 4 (byte enables, 0 = read), sram_addr out SRAM_AW, sram_wdata out 32, sram_rdata in 32 (valid the cycle after a read sram_en).

Function
REQ-009 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_RESP; one transaction in flight at a time.
REQ-010 SHALL assert arready/awready only in IDLE; with both arvalid and awvalid high in IDLE, SHALL grant the channel not granted last time (toggle flag, reset value favours read).
REQ-011 SHALL on AR handshake latch arid, araddr[SRAM_AW+1:2], arlen, arburst; beat counter cleared; next state RD_REQ.
REQ-012 SHALL in RD_REQ drive sram_en=1, sram_we=0, sram_addr=current word address; next state RD_WAIT.
REQ-013 SHALL in RD_WAIT capture sram_rdata into an output register; next state RD_RESP.
REQ-014 SHALL in RD_RESP hold rvalid=1 with stable rid/rdata/rresp/rlast until rready; rlast=1 iff beat counter == latched len.
REQ-015 SHALL on R handshake with rlast go to IDLE; otherwise increment beat counter, advance address, go to RD_REQ (3 cycles per beat minimum).
REQ-016 SHALL on AW handshake latch awid, word address, awlen, awburst; clear beat counter; go to WR_DATA.
REQ-017 SHALL in WR_DATA drive wready=1 and, on each W handshake, same cycle: sram_en=1, sram_we=wstrb, sram_addr=current address, sram_wdata=wdata; then advance address and counter.
REQ-018 SHALL on W handshake with wlast=1 go to WR_RESP; bresp=2'b10 (SLVERR) if that beat's counter != awlen, else 2'b00.
REQ-019 SHALL in WR_RESP hold bvalid=1, bid=latched id until bready; then IDLE.
REQ-020 SHALL advance address by +1 word for INCR (2'b01), hold for FIXED (2'b00); address wraps modulo 2^SRAM_AW.
REQ-021 SHALL treat arburst/awburst=2'b10 or 2'b11 as unsupported: no SRAM access (sram_en=0), reads return rdata=0 rresp=SLVERR per beat, write beats accepted and discarded, bresp=SLVERR.
REQ-022 SHALL ignore arsize/awsize; addresses are word-aligned, araddr[1:0]/awaddr[1:0] ignored.
REQ-023 SHALL keep sram_en=0 and sram_we=0 in every state/cycle not listed in REQ-012/REQ-017.

Reset
REQ-024 SHALL, while areset=1 on a clock edge, enter IDLE, clear counters, grant flag to read, and drive arready=awready=rvalid=wready=bvalid=sram_en=0, sram_we=0, rdata=0, rresp=0, bresp=0, rlast=0.
REQ-025 SHALL abandon any in-flight transaction on reset with no further R/B beats; arready/awready rise the first cycle after areset falls.

Verification
REQ-026 Single read: preload word 0x10 = 0xDEADBEEF, AR araddr=0x40 arlen=0 arid=3 at cycle T -> sram_en at T+1 addr 0x10, rvalid at T+3 rdata=0xDEADBEEF rid=3 rlast=1 rresp=0.
REQ-027 INCR write burst: awaddr=0x100 awlen=3, 4 beats wstrb=0xF, wlast on 4th -> sram writes at word 0x40..0x43, bvalid bresp=0 bid echoed; readback arlen=3 returns same 4 words, rlast on 4th only.
REQ-028 Backpressure/strobe: rready low 5 cycles during read beat -> rdata stable, no extra sram_en; write wstrb=0x3 -> only low halfword changes.
REQ-029 Arbitration/wrap: arvalid and awvalid together twice from IDLE after reset -> read granted first, write second; INCR burst from word 2^SRAM_AW-1 wraps to word 0.
REQ-030 Errors/reset: awlen=3 with wlast on beat 2 -> bresp=SLVERR; arburst=2'b10 -> rresp=SLVERR, rdata=0, no sram_en; areset mid-read -> no rvalid afterwards, IDLE outputs per REQ-024.
